// File: rtl/branch_resolve.sv
// Branch resolution stage: carries predictor metadata from IF through ID to EX,
// resolves the real next PC, emits predictor update strobes and pipeline flushes.
module branch_resolve #(
    parameter int ENTRYNUM = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_pc_pre,
    input  logic        if_hit,
    input  logic [2:0]  if_hitpos,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic [31:0] pc_ex,
    output logic [31:0] pc_npc,
    output logic [2:0]  hitpos_ex,
    output logic        hit_ex,
    output logic        preright_ex,
    output logic        branch_ex,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] pc_pre;
        logic        hit;
        logic [2:0]  hitpos;
    } slot_t;

    // hitpos is a fixed 3-bit field, so a larger table cannot be addressed
    generate
        if (ENTRYNUM < 1 || ENTRYNUM > 8) begin : g_entrynum_range
            $error("branch_resolve: ENTRYNUM must be within 1..8");
        end
    endgenerate

    slot_t       id_r;
    slot_t       ex_r;
    slot_t       if_slot_s;
    logic [31:0] npc_s;
    logic        flush_s;
    logic        branch_s;
    logic [31:0] br_cnt_r;
    logic [31:0] miss_cnt_r;

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            sat_inc = val;
        end else begin
            sat_inc = val + 32'd1;
        end
    endfunction

    // Pack the IF-stage predictor metadata into a slot
    always_comb begin
        if_slot_s        = '0;
        if_slot_s.v      = if_valid;
        if_slot_s.pc     = if_pc;
        if_slot_s.pc_pre = if_pc_pre;
        if_slot_s.hit    = if_hit;
        if_slot_s.hitpos = if_hitpos;
    end

    // Actual next PC of the EX instruction; the +1 wraps naturally at 32 bits
    always_comb begin
        npc_s = 32'd0;
        if (ex_is_branch && ex_taken) begin
            npc_s = ex_target;
        end else begin
            npc_s = ex_r.pc + 32'd1;
        end
    end

    // Strobe and flush are gated by stall so a held EX slot is evaluated once
    always_comb begin
        flush_s  = 1'b0;
        branch_s = 1'b0;
        if (ex_r.v && !stall) begin
            flush_s  = (ex_r.pc_pre != npc_s);
            branch_s = ex_is_branch;
        end else begin
            flush_s  = 1'b0;
            branch_s = 1'b0;
        end
    end

    // ID/EX metadata slots: reset, hold on stall, squash on flush, else shift
    always_ff @(posedge clk) begin
        if (rst) begin
            id_r <= '0;
            ex_r <= '0;
        end else if (stall) begin
            id_r <= id_r;
            ex_r <= ex_r;
        end else if (flush_s) begin
            id_r.v <= 1'b0;
            ex_r.v <= 1'b0;
        end else begin
            ex_r <= id_r;
            id_r <= if_slot_s;
        end
    end

    // Saturating event counters; branch_s/flush_s are already stall-qualified
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_r   <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            if (branch_s) begin
                br_cnt_r <= sat_inc(br_cnt_r);
            end else begin
                br_cnt_r <= br_cnt_r;
            end
            if (flush_s) begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
        end
    end

    assign pc_ex       = ex_r.pc;
    assign pc_npc      = npc_s;
    assign hitpos_ex   = ex_r.hitpos;
    assign hit_ex      = ex_r.hit;
    assign preright_ex = (ex_r.pc_pre == npc_s);
    assign branch_ex   = branch_s;
    assign flush       = flush_s;
    assign redirect_pc = flush_s ? npc_s : 32'd0;
    assign br_cnt      = br_cnt_r;
    assign miss_cnt    = miss_cnt_r;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed IF/EX vectors push expected
// update/flush events; a negedge monitor pops and compares them.
module tb_branch_resolve;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_pre;
    logic        if_hit;
    logic [2:0]  if_hitpos;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] pc_ex;
    logic [31:0] pc_npc;
    logic [2:0]  hitpos_ex;
    logic        hit_ex;
    logic        preright_ex;
    logic        branch_ex;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [2:0]  hitpos;
        logic        hit;
        logic        preright;
        logic        br;
        logic        fl;
        logic [31:0] redir;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;

    branch_resolve #(.ENTRYNUM(8)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc_pre(if_pc_pre),
        .if_hit(if_hit), .if_hitpos(if_hitpos),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
        .pc_ex(pc_ex), .pc_npc(pc_npc), .hitpos_ex(hitpos_ex), .hit_ex(hit_ex),
        .preright_ex(preright_ex), .branch_ex(branch_ex), .flush(flush),
        .redirect_pc(redirect_pc), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic v, input logic [31:0] pc, input logic [31:0] pre,
                          input logic hit, input logic [2:0] hp);
        if_valid  = v;
        if_pc     = pc;
        if_pc_pre = pre;
        if_hit    = hit;
        if_hitpos = hp;
    endtask

    task automatic set_ex(input logic br, input logic tk, input logic [31:0] tgt);
        ex_is_branch = br;
        ex_taken     = tk;
        ex_target    = tgt;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] npc, input logic [2:0] hp,
                        input logic hit, input logic pr, input logic br, input logic fl,
                        input logic [31:0] redir);
        exp_t e;
        e.pc = pc; e.npc = npc; e.hitpos = hp; e.hit = hit;
        e.preright = pr; e.br = br; e.fl = fl; e.redir = redir;
        sb_q.push_back(e);
    endtask

    // Monitor: every strobe or flush must match the next scoreboard entry
    always @(negedge clk) begin
        if (branch_ex === 1'b1 || flush === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_event: branch_ex=%b flush=%b pc_ex=%h expected none",
                         branch_ex, flush, pc_ex);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pc_ex", pc_ex, mon_e.pc);
                chk("pc_npc", pc_npc, mon_e.npc);
                chk("hitpos_ex", 32'(hitpos_ex), 32'(mon_e.hitpos));
                chk("hit_ex", 32'(hit_ex), 32'(mon_e.hit));
                chk("preright_ex", 32'(preright_ex), 32'(mon_e.preright));
                chk("branch_ex", 32'(branch_ex), 32'(mon_e.br));
                chk("flush", 32'(flush), 32'(mon_e.fl));
                chk("redirect_pc", redirect_pc, mon_e.redir);
            end
        end
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        set_if(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        set_ex(1'b0, 1'b0, 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_pc_ex", pc_ex, 32'd0);
        chk("rst_pc_npc", pc_npc, 32'd1);
        chk("rst_branch_ex", 32'(branch_ex), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_hit_hitpos", {28'd0, hit_ex, hitpos_ex}, 32'd0);
        chk("rst_preright", 32'(preright_ex), 32'd0);
        chk("rst_br_cnt", br_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);

        // Correct taken prediction
        set_if(1'b1, 32'h10, 32'h40, 1'b1, 3'd3);
        step();
        set_if(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        step();
        set_ex(1'b1, 1'b1, 32'h40);
        push(32'h10, 32'h40, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        step();
        set_ex(1'b0, 1'b0, 32'd0);
        chk("t1_br_cnt", br_cnt, 32'd1);
        chk("t1_miss_cnt", miss_cnt, 32'd0);

        // Mispredicted not-taken; younger ID and IF instructions must be squashed
        set_if(1'b1, 32'h20, 32'h21, 1'b0, 3'd0);
        step();
        set_if(1'b1, 32'h21, 32'h99, 1'b1, 3'd1);
        step();
        set_if(1'b1, 32'h81, 32'h99, 1'b1, 3'd2);
        set_ex(1'b1, 1'b1, 32'h80);
        push(32'h20, 32'h80, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
        step();
        set_ex(1'b0, 1'b0, 32'd0);
        set_if(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) step();
        chk("t2_br_cnt", br_cnt, 32'd2);
        chk("t2_miss_cnt", miss_cnt, 32'd1);

        // Stale hit on a non-branch
        set_if(1'b1, 32'h30, 32'h50, 1'b1, 3'd5);
        step();
        set_if(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        step();
        push(32'h30, 32'h31, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h31);
        step();
        step();
        chk("t3_br_cnt", br_cnt, 32'd2);
        chk("t3_miss_cnt", miss_cnt, 32'd2);

        // Stall held over a mispredicted EX slot
        set_if(1'b1, 32'h40, 32'h41, 1'b0, 3'd0);
        step();
        set_if(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        step();
        stall = 1'b1;
        set_ex(1'b1, 1'b1, 32'h60);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_stall_flush", 32'(flush), 32'd0);
            chk("t4_stall_branch", 32'(branch_ex), 32'd0);
            step();
        end
        chk("t4_stall_br_cnt", br_cnt, 32'd2);
        chk("t4_stall_miss_cnt", miss_cnt, 32'd2);
        stall = 1'b0;
        push(32'h40, 32'h60, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h60);
        step();
        set_ex(1'b0, 1'b0, 32'd0);
        step();
        step();
        chk("t4_br_cnt", br_cnt, 32'd3);
        chk("t4_miss_cnt", miss_cnt, 32'd3);

        // Reset while both slots are valid and stalled on a would-be flush
        set_if(1'b1, 32'h50, 32'h77, 1'b1, 3'd4);
        step();
        set_if(1'b1, 32'h51, 32'h88, 1'b1, 3'd6);
        step();
        rst = 1'b1;
        stall = 1'b1;
        step();
        rst = 1'b0;
        stall = 1'b0;
        set_if(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        #1;
        chk("t5_flush", 32'(flush), 32'd0);
        chk("t5_branch_ex", 32'(branch_ex), 32'd0);
        chk("t5_pc_ex", pc_ex, 32'd0);
        chk("t5_br_cnt", br_cnt, 32'd0);
        chk("t5_miss_cnt", miss_cnt, 32'd0);
        step();
        step();

        // PC wrap: 0xFFFFFFFF not taken resolves to 0
        set_if(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 3'd7);
        step();
        set_if(1'b0, 32'd0, 32'd0, 1'b0, 3'd0);
        step();
        #1;
        chk("wrap_pc_npc", pc_npc, 32'd0);
        chk("wrap_preright", 32'(preright_ex), 32'd1);
        chk("wrap_hitpos", 32'(hitpos_ex), 32'd7);
        chk("wrap_flush", 32'(flush), 32'd0);
        step();
        step();
        chk("wrap_miss_cnt", miss_cnt, 32'd0);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
